inert_yaw_rdr: RTL and testbench

Command sequencer that sits directly upstream of the SPI monarch and drives the inertial sensor. After reset it waits out sensor power-up, writes three configuration registers, then services every sensor data-ready interrupt by reading yawL/yawH. It presents each result as a 16-bit signed yaw rate with a one-cycle valid strobe to the heading integrator.

---
 rtl/inert_pkg.sv | 26 ++
 rtl/yaw_offset_cal.sv | 53 +++++
 rtl/inert_yaw_rdr.sv | 135 +++++++++++++
 tb/tb_inert_yaw_rdr.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inert_pkg.sv
// Shared state encoding, sensor command words and saturation helper for inert_yaw_rdr.
package inert_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    CFG_INT,
    CFG_ODR,
    CFG_RND,
    IDLE,
    RD_L,
    RD_H
  } state_t;

  localparam logic [15:0] CMD_INT_CFG = 16'h0D02;
  localparam logic [15:0] CMD_ODR     = 16'h1160;
  localparam logic [15:0] CMD_RND     = 16'h1440;
  localparam logic [15:0] CMD_YAWL    = 16'hA600;
  localparam logic [15:0] CMD_YAWH    = 16'hA700;

  // Clamp a 17-bit signed difference into the 16-bit signed range.
  function automatic logic [15:0] sat16(input logic [16:0] d);
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7FFF;
    return d[15:0];
  endfunction

endpackage

// File: rtl/yaw_offset_cal.sv
// Start-up offset calibration: averages the first 2^CAL_SAMPLES_LOG2 readings,
// then outputs raw minus that offset, saturated. Used only when YAW_CAL_EN is defined.
module yaw_offset_cal
  import inert_pkg::*;
#(
  parameter int unsigned CAL_SAMPLES_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] raw,
  input  logic        raw_vld,
  output logic        cal_done,
  output logic [15:0] yaw_out,
  output logic        out_vld
);

  localparam int unsigned CW = CAL_SAMPLES_LOG2 + 1;
  localparam logic [CW-1:0] LAST_SMP = CW'((1 << CAL_SAMPLES_LOG2) - 1);

  logic [CW-1:0]       smp_cnt;
  logic signed [19:0]  acc;
  logic signed [19:0]  acc_nxt;
  logic signed [19:0]  avg;
  logic signed [15:0]  offset;
  logic [16:0]         diff;

  assign acc_nxt = acc + {{4{raw[15]}}, raw};
  assign avg     = acc_nxt >>> CAL_SAMPLES_LOG2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt  <= '0;
      acc      <= '0;
      offset   <= '0;
      cal_done <= 1'b0;
    end else if (raw_vld && !cal_done) begin
      acc     <= acc_nxt;
      smp_cnt <= smp_cnt + 1'b1;
      if (smp_cnt == LAST_SMP) begin
        offset   <= avg[15:0];
        cal_done <= 1'b1;
      end
    end
  end

  // Combinational so the top registers the result in the same cycle as the raw capture.
  always_comb begin
    diff    = {raw[15], raw} - {offset[15], offset};
    yaw_out = sat16(diff);
    out_vld = raw_vld & cal_done;
  end

endmodule

// File: rtl/inert_yaw_rdr.sv
// Yaw-rate reader: power-up wait, three config writes, then a yawL/yawH read per INT.
// Define YAW_CAL_EN to add start-up offset calibration (yaw_offset_cal).
module inert_yaw_rdr
  import inert_pkg::*;
#(
  parameter int unsigned PWRUP_CLKS       = 65536,
  parameter int unsigned CAL_SAMPLES_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        rdy
);

  localparam logic [15:0] PWR_LAST = 16'(PWRUP_CLKS - 1);

  state_t      state;
  logic [15:0] pwr_cnt;
  logic        int_ff1;
  logic        int_s;
  logic        done_q;
  logic        done_rise;
  logic [7:0]  yaw_l;
  logic [15:0] raw;
  logic [15:0] yaw_next;
  logic        yaw_take;
  logic        init_done;
  logic        unused_bits;

  assign done_rise = done & ~done_q;
  assign raw       = {rd_data[7:0], yaw_l};

`ifdef YAW_CAL_EN
  logic cal_done;

  yaw_offset_cal #(
    .CAL_SAMPLES_LOG2(CAL_SAMPLES_LOG2)
  ) u_cal (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (raw),
    .raw_vld ((state == RD_H) && done_rise),
    .cal_done(cal_done),
    .yaw_out (yaw_next),
    .out_vld (yaw_take)
  );

  assign rdy         = init_done & cal_done;
  assign unused_bits = ^rd_data[15:8];
`else
  assign yaw_next    = raw;
  assign yaw_take    = 1'b1;
  assign rdy         = init_done;
  assign unused_bits = ^{rd_data[15:8], 1'(CAL_SAMPLES_LOG2)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_s   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_s   <= int_ff1;
      done_q  <= done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWRUP;
      pwr_cnt   <= '0;
      wrt       <= 1'b0;
      cmd       <= '0;
      yaw_l     <= '0;
      yaw_rt    <= '0;
      vld       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        PWRUP: begin
          if (pwr_cnt == PWR_LAST) begin
            state <= CFG_INT;
            wrt   <= 1'b1;
            cmd   <= CMD_INT_CFG;
          end else begin
            pwr_cnt <= pwr_cnt + 16'd1;
          end
        end
        CFG_INT: if (done_rise) begin
          state <= CFG_ODR;
          wrt   <= 1'b1;
          cmd   <= CMD_ODR;
        end
        CFG_ODR: if (done_rise) begin
          state <= CFG_RND;
          wrt   <= 1'b1;
          cmd   <= CMD_RND;
        end
        CFG_RND: if (done_rise) begin
          state     <= IDLE;
          init_done <= 1'b1;
        end
        IDLE: if (int_s) begin
          state <= RD_L;
          wrt   <= 1'b1;
          cmd   <= CMD_YAWL;
        end
        RD_L: if (done_rise) begin
          yaw_l <= rd_data[7:0];
          state <= RD_H;
          wrt   <= 1'b1;
          cmd   <= CMD_YAWH;
        end
        RD_H: if (done_rise) begin
          state <= IDLE;
          if (yaw_take) begin
            yaw_rt <= yaw_next;
            vld    <= 1'b1;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_yaw_rdr.sv
// Bench for inert_yaw_rdr with a behavioural SPI monarch / sensor model; honours YAW_CAL_EN.
module tb_inert_yaw_rdr;

  localparam int unsigned PWR  = 64;
  localparam int unsigned LOG2 = 1;
  localparam int          N    = 1 << LOG2;
`ifdef YAW_CAL_EN
  localparam bit CAL = 1'b1;
`else
  localparam bit CAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_line = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = '0;
  logic        wrt, vld, rdy;
  logic [15:0] cmd, yaw_rt;

  int checks = 0;
  int fails  = 0;

  inert_yaw_rdr #(
    .PWRUP_CLKS      (PWR),
    .CAL_SAMPLES_LOG2(LOG2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .INT    (int_line),
    .done   (done),
    .rd_data(rd_data),
    .wrt    (wrt),
    .cmd    (cmd),
    .yaw_rt (yaw_rt),
    .vld    (vld),
    .rdy    (rdy)
  );

  always #10 clk = ~clk;

  // Monarch + sensor model state
  logic [15:0] cmd_log[$];
  logic [15:0] cur_cmd = '0;
  logic [15:0] last_cmd = '0;
  logic [7:0]  yaw_lo = '0;
  logic [7:0]  yaw_hi = '0;
  logic        nemo_setup = 1'b0;
  int          ncompl = 0;
  int          busy = 0;
  int          hold = 0;
  int          int_cnt = 0;
  int          int_seen = 0;
  int          glitch_cnt = 0;
  int          glitch_seen = 0;
  bit          glitch_up = 1'b0;

  always @(negedge clk) begin
    if (int_seen != int_cnt) begin
      int_line = 1'b1;
      int_seen = int_cnt;
    end
    if (!rst_n) begin
      done = 1'b0; busy = 0; hold = 0; ncompl = 0;
      cmd_log.delete();
      glitch_up = 1'b0; glitch_seen = glitch_cnt;
    end else if (wrt) begin
      cmd_log.push_back(cmd);
      cur_cmd = cmd;
      hold = int'($urandom_range(0, 3));
      busy = int'($urandom_range(2, 8));
      if (cmd == 16'h0D02) nemo_setup = 1'b0;
      if (hold == 0) done = 1'b0;
    end else if (hold != 0) begin
      hold--;
      if (hold == 0) done = 1'b0;
    end else if (busy != 0) begin
      busy--;
      if (busy == 0) begin
        done = 1'b1;
        ncompl++;
        last_cmd = cur_cmd;
        case (cur_cmd)
          16'hA600: begin rd_data = {8'($urandom), yaw_lo}; int_line = 1'b0; end
          16'hA700: rd_data = {8'($urandom), yaw_hi};
          16'h0D02: begin rd_data = 16'($urandom); nemo_setup = 1'b1; end
          default:  rd_data = 16'($urandom);
        endcase
      end
    end else if (glitch_seen != glitch_cnt) begin
      done = 1'b0; glitch_seen = glitch_cnt; glitch_up = 1'b1;
    end else if (glitch_up) begin
      done = 1'b1; glitch_up = 1'b0;
    end
  end

  // Reference model: average of the first N readings, then saturated raw - offset.
  int          cal_n, cal_sum, cal_off;
  logic [15:0] prev;

  task automatic model_reset();
    cal_n = 0; cal_sum = 0; cal_off = 0; prev = '0;
  endtask

  task automatic model_step(input logic [15:0] raw, output bit ev, output logic [15:0] val);
    int r, d;
    r = int'($signed(raw));
    if (CAL && cal_n < N) begin
      cal_sum += r;
      cal_n++;
      if (cal_n == N) cal_off = cal_sum >>> LOG2;
      ev = 1'b0; val = prev;
    end else begin
      d = r - cal_off;
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
      ev = 1'b1; val = 16'(d);
    end
  endtask

  function automatic logic model_rdy();
    return CAL ? (cal_n == N) : 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_compl(input int target, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ncompl >= target) begin ok = 1'b1; break; end
      tick();
    end
    chk({name, "_reached"}, 32'(ok), 1);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_wrt"}, 32'(wrt), 0);
    chk({name, "_cmd"}, 32'(cmd), 0);
    chk({name, "_yaw"}, 32'(yaw_rt), 0);
    chk({name, "_vld"}, 32'(vld), 0);
    chk({name, "_rdy"}, 32'(rdy), 0);
  endtask

  task automatic run_init();
    int n = 0;
    bit seen = 1'b0;
    while (n < 200 && !seen) begin
      tick();
      n++;
      if (wrt) seen = 1'b1;
    end
    chk("pwrup_delay", 32'(n), PWR);
    chk("cmd_int_cfg", 32'(cmd), 32'h0D02);
    wait_compl(1, "cfg_int");
    chk("nemo_setup", 32'(nemo_setup), 1);
    wait_compl(3, "cfg_rnd");
    chk("rdy_before", 32'(rdy), 0);
    tick();
    chk("rdy_after_init", 32'(rdy), 32'(model_rdy()));
    chk("init_cmd_count", 32'(cmd_log.size()), 3);
    if (cmd_log.size() == 3) begin
      chk("init_cmd0", 32'(cmd_log[0]), 32'h0D02);
      chk("init_cmd1", 32'(cmd_log[1]), 32'h1160);
      chk("init_cmd2", 32'(cmd_log[2]), 32'h1440);
    end
  endtask

  task automatic expect_result(input logic [15:0] raw, input string name);
    bit          ev, ok, bad;
    logic [15:0] val;
    int          start;
    model_step(raw, ev, val);
    ok = 1'b0; bad = 1'b0; start = ncompl;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ncompl != start && last_cmd == 16'hA700) begin ok = 1'b1; break; end
      if (vld !== 1'b0 || yaw_rt !== prev) bad = 1'b1;
    end
    chk({name, "_rdh_done"}, 32'(ok), 1);
    chk({name, "_hold"}, 32'({bad, vld, yaw_rt}), 32'({1'b0, 1'b0, prev}));
    tick();
    chk({name, "_vld"}, 32'(vld), 32'(ev));
    chk({name, "_yaw"}, 32'(yaw_rt), 32'(val));
    chk({name, "_rdy"}, 32'(rdy), 32'(model_rdy()));
    tick();
    chk({name, "_vld_1cyc"}, 32'(vld), 0);
    if (cmd_log.size() >= 2)
      chk({name, "_cmds"}, {cmd_log[cmd_log.size()-2], cmd_log[cmd_log.size()-1]}, 32'hA600A700);
    prev = val;
  endtask

  task automatic do_reading(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] raw,
                            input string name);
    yaw_lo = lo; yaw_hi = hi;
    int_cnt++;
    tick();
    tick(); chk({name, "_lat1"}, 32'(wrt), 0);
    tick(); chk({name, "_lat2"}, 32'(wrt), 0);
    tick(); chk({name, "_int_wrt"}, 32'(wrt), 1);
    chk({name, "_cmd_yawl"}, 32'(cmd), 32'hA600);
    expect_result(raw, name);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] raw;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    bit ok;
    logic [7:0] lo, hi;

    tbl[0] = '{8'h8D, 8'h99, 16'h998D};
    tbl[1] = '{8'h3D, 8'hCD, 16'hCD3D};
    tbl[2] = '{8'h00, 8'h80, 16'h8000};
    tbl[3] = '{8'hFF, 8'h7F, 16'h7FFF};
    tbl[4] = '{8'h00, 8'h00, 16'h0000};
    tbl[5] = '{8'hFF, 8'hFF, 16'hFFFF};

    model_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    run_init();

    // done rising while IDLE must not start anything
    glitch_cnt++;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wrt) saw = 1'b1;
    end
    chk("idle_done_ignored", 32'(saw), 0);

    for (int i = 0; i < 6; i++)
      do_reading(tbl[i].lo, tbl[i].hi, tbl[i].raw, $sformatf("tbl%0d", i));

    for (int i = 0; i < 12; i++) begin
      lo = 8'($urandom);
      hi = 8'($urandom);
      do_reading(lo, hi, {hi, lo}, $sformatf("rnd%0d", i));
    end

    // Reset while RD_L is in flight; INT stays pending across the reset
    yaw_lo = 8'h00; yaw_hi = 8'h80;
    int_cnt++;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wrt && cmd == 16'hA600) begin ok = 1'b1; break; end
    end
    chk("rdl_reached", 32'(ok), 1);
    tick();
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid_reset");
    tick();
    rst_n = 1'b1;
    model_reset();
    run_init();
    expect_result(16'h8000, "pending");

`ifdef YAW_CAL_EN
    do_reading(8'h00, 8'h80, 16'h8000, "cal_neg");
    do_reading(8'hFF, 8'h7F, 16'h7FFF, "sat_hi");
    chk("sat_const", 32'(yaw_rt), 32'h7FFF);
    do_reading(8'h00, 8'h80, 16'h8000, "sat_zero");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
